obstacle_scan_ctrl: RTL and testbench

Sequencing controller for the obstacle map ROM. It owns the 2-bit map select that drives the obstacle table's `random_seed` input. It also serves bounding-box collision queries from the game logic by scanning the 12 obstacle rectangles one per clock, using a valid/ready handshake on both the query and the result. Map changes are deferred so the obstacle set never changes during a scan.

---
 rtl/obs_pkg.sv | 22 ++
 rtl/rect_overlap.sv | 14 +
 rtl/obstacle_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_obstacle_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/obs_pkg.sv
// Shared types and constants for the obstacle map and collision logic.
package obs_pkg;

    localparam int NUM_OBS = 12;
    localparam int IDX_W   = 4;
    localparam int SCR_W   = 640;
    localparam int SCR_H   = 480;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

    typedef struct packed {
        logic [9:0] left;
        logic [9:0] right;
        logic [8:0] top;
        logic [8:0] bottom;
    } rect_t;

endpackage

// File: rtl/rect_overlap.sv
// Half-open rectangle overlap test; edge-touching boxes do not overlap.
module rect_overlap
    import obs_pkg::*;
(
    input  rect_t a_i,
    input  rect_t b_i,
    output logic  hit_o
);

    // Unsigned compares at native field widths.
    assign hit_o = (a_i.left < b_i.right) && (a_i.right > b_i.left) &&
                   (a_i.top  < b_i.bottom) && (a_i.bottom > b_i.top);

endmodule

// File: rtl/obstacle_scan_ctrl.sv
// Map-select sequencing and serial bounding-box collision scan over the
// obstacle table, one obstacle per clock, with valid/ready on query and result.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a query; a pending map change is applied here
// SCAN  | comparing the registered query box against obstacle idx
// DONE  | result held on r_hit/r_idx until the consumer takes it
module obstacle_scan_ctrl #(
    parameter int NUM_OBS = 12,
    parameter int IDX_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     new_map,
    output logic [1:0]               map_sel,
    input  logic [NUM_OBS-1:0][9:0]  obs_left,
    input  logic [NUM_OBS-1:0][9:0]  obs_right,
    input  logic [NUM_OBS-1:0][8:0]  obs_top,
    input  logic [NUM_OBS-1:0][8:0]  obs_bottom,
    input  logic                     q_valid,
    output logic                     q_ready,
    input  logic [9:0]               q_left,
    input  logic [9:0]               q_right,
    input  logic [8:0]               q_top,
    input  logic [8:0]               q_bottom,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic                     r_hit,
    output logic [IDX_W-1:0]         r_idx
);

    import obs_pkg::*;

    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    rect_t            box_q, box_d;
    logic             r_hit_q, r_hit_d;
    logic [IDX_W-1:0] r_idx_q, r_idx_d;
    logic [1:0]       map_sel_q, map_sel_d;
    logic [1:0]       seed_cnt_q;
    logic             map_pend_q, map_pend_d;

    rect_t            obs_cur;
    logic             hit;
    logic             pend_any;

    // Select the obstacle currently under test.
    always_comb begin
        obs_cur.left   = obs_left[idx_q];
        obs_cur.right  = obs_right[idx_q];
        obs_cur.top    = obs_top[idx_q];
        obs_cur.bottom = obs_bottom[idx_q];
    end

    rect_overlap u_overlap (
        .a_i   (box_q),
        .b_i   (obs_cur),
        .hit_o (hit)
    );

    // Scan FSM next-state and result capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        box_d   = box_q;
        r_hit_d = r_hit_q;
        r_idx_d = r_idx_q;
        case (state_q)
            IDLE: begin
                if (q_valid) begin
                    box_d   = '{left: q_left, right: q_right, top: q_top, bottom: q_bottom};
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    r_hit_d = 1'b1;
                    r_idx_d = idx_q;
                    state_d = DONE;
                end else if (idx_q == IDX_W'(NUM_OBS - 1)) begin
                    r_hit_d = 1'b0;
                    r_idx_d = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (r_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Map changes are held off until IDLE so the obstacle set is frozen during a scan;
    // the chosen seed is bumped by one when it would leave the map unchanged.
    always_comb begin
        pend_any   = map_pend_q | new_map;
        map_sel_d  = map_sel_q;
        map_pend_d = pend_any;
        if (pend_any && (state_q == IDLE)) begin
            map_sel_d  = (seed_cnt_q == map_sel_q) ? seed_cnt_q + 2'd1 : seed_cnt_q;
            map_pend_d = 1'b0;
        end
    end

    // State, scan and map registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            box_q      <= '0;
            r_hit_q    <= 1'b0;
            r_idx_q    <= '0;
            map_sel_q  <= 2'd0;
            seed_cnt_q <= 2'd0;
            map_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            box_q      <= box_d;
            r_hit_q    <= r_hit_d;
            r_idx_q    <= r_idx_d;
            map_sel_q  <= map_sel_d;
            seed_cnt_q <= seed_cnt_q + 2'd1;
            map_pend_q <= map_pend_d;
        end
    end

    assign q_ready = (state_q == IDLE);
    assign r_valid = (state_q == DONE);
    assign r_hit   = r_hit_q;
    assign r_idx   = r_idx_q;
    assign map_sel = map_sel_q;

endmodule

// File: tb/tb_obstacle_scan_ctrl.sv
// Self-checking bench for obstacle_scan_ctrl with a behavioural obstacle table.
module tb_obstacle_scan_ctrl;

    localparam int N = 12;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic new_map = 1'b0;
    logic q_valid = 1'b0;
    logic r_ready = 1'b0;
    logic [1:0] map_sel;
    logic [N-1:0][9:0] obs_left, obs_right;
    logic [N-1:0][8:0] obs_top, obs_bottom;
    logic q_ready, r_valid, r_hit;
    logic [9:0] q_left = '0, q_right = '0;
    logic [8:0] q_top = '0, q_bottom = '0;
    logic [3:0] r_idx;

    int checks = 0;
    int failures = 0;
    int cyc;

    logic [9:0] tl [4][N];
    logic [9:0] tr [4][N];
    logic [8:0] tt [4][N];
    logic [8:0] tbm [4][N];

    typedef struct {
        int map, l, r, t, b, hit, idx, lat;
    } vec_t;
    vec_t vecs [6];

    obstacle_scan_ctrl #(.NUM_OBS(N), .IDX_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .new_map(new_map), .map_sel(map_sel),
        .obs_left(obs_left), .obs_right(obs_right), .obs_top(obs_top), .obs_bottom(obs_bottom),
        .q_valid(q_valid), .q_ready(q_ready), .q_left(q_left), .q_right(q_right),
        .q_top(q_top), .q_bottom(q_bottom), .r_valid(r_valid), .r_ready(r_ready),
        .r_hit(r_hit), .r_idx(r_idx)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; equals the DUT seed counter modulo 4.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    // Obstacle table: a pure function of map_sel.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            obs_left[i]   = tl[map_sel][i];
            obs_right[i]  = tr[map_sel][i];
            obs_top[i]    = tt[map_sel][i];
            obs_bottom[i] = tbm[map_sel][i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input int m, input int l, r, t, b,
                                  output int hit, output int idx, output int lat);
        hit = 0; idx = 0; lat = N;
        for (int i = 0; i < N; i++) begin
            if (hit == 0 && l < int'(tr[m][i]) && r > int'(tl[m][i]) &&
                t < int'(tbm[m][i]) && b > int'(tt[m][i])) begin
                hit = 1; idx = i; lat = i + 1;
            end
        end
    endfunction

    function automatic int predict();
        int s;
        s = cyc % 4;
        return (s == int'(map_sel)) ? (s + 1) % 4 : s;
    endfunction

    task automatic pulse_map();
        int p;
        p = predict();
        new_map = 1'b1;
        @(negedge clk);
        new_map = 1'b0;
        chk("map_apply", map_sel, p);
    endtask

    task automatic set_map(input int target);
        for (int k = 0; k < 30 && int'(map_sel) != target; k++) begin
            pulse_map();
            if ($urandom % 2 == 1) @(negedge clk);
        end
        chk("set_map", map_sel, target);
    endtask

    // Called just after a negedge in IDLE; returns just after a negedge in DONE.
    task automatic query(input int l, r, t, b, input bit with_map, input int p1, p2,
                         output int hit, output int idx, output int lat);
        int pm, m;
        chk("q_ready_idle", q_ready, 1);
        pm = predict();
        q_left = 10'(l); q_right = 10'(r); q_top = 9'(t); q_bottom = 9'(b);
        q_valid = 1'b1;
        new_map = with_map;
        @(negedge clk);
        q_valid = 1'b0;
        new_map = 1'b0;
        if (with_map) chk("map_with_query", map_sel, pm);
        m = int'(map_sel);
        lat = 0;
        while (!r_valid && lat < 40) begin
            chk("q_ready_busy", q_ready, 0);
            new_map = (lat == p1 || lat == p2);
            @(posedge clk);
            lat++;
            @(negedge clk);
            new_map = 1'b0;
            chk("map_stable_scan", map_sel, m);
        end
        chk("r_valid_seen", r_valid, 1);
        hit = int'(r_hit);
        idx = int'(r_idx);
    endtask

    task automatic release_result();
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        chk("q_ready_after", q_ready, 1);
        chk("r_valid_after", r_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int hit, idx, lat, ehit, eidx, elat, m, l, r, t, b, j, old, p;
        bit wm;

        // Map 0: obstacle 0 at 50..80 x 50..90, the rest on a diagonal well left of x=600.
        for (int i = 0; i < N; i++) begin
            tl[0][i] = 10'(150 + 30 * i); tr[0][i] = 10'(170 + 30 * i);
            tt[0][i] = 9'(100 + 20 * i);  tbm[0][i] = 9'(115 + 20 * i);
        end
        tl[0][0] = 10'd50; tr[0][0] = 10'd80; tt[0][0] = 9'd50; tbm[0][0] = 9'd90;
        for (int mm = 1; mm < 4; mm++)
            for (int i = 0; i < N; i++) begin
                tl[mm][i] = 10'($urandom_range(0, 560));
                tr[mm][i] = tl[mm][i] + 10'($urandom_range(5, 60));
                tt[mm][i] = 9'($urandom_range(0, 420));
                tbm[mm][i] = tt[mm][i] + 9'($urandom_range(5, 50));
            end
        tl[1][0] = 10'd80; tr[1][0] = 10'd95;  tt[1][0] = 9'd220; tbm[1][0] = 9'd240;
        tl[1][1] = 10'd95; tr[1][1] = 10'd120; tt[1][1] = 9'd240; tbm[1][1] = 9'd260;

        vecs[0] = '{0, 60, 70, 60, 70, 1, 0, 1};
        vecs[1] = '{0, 610, 630, 10, 30, 0, 0, 12};
        vecs[2] = '{0, 80, 90, 50, 90, 0, 0, 12};
        vecs[3] = '{1, 90, 100, 230, 250, 1, 0, 1};
        vecs[4] = '{0, 305, 310, 205, 210, 1, 5, 6};
        vecs[5] = '{0, 470, 485, 330, 340, 1, 11, 12};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_map_sel", map_sel, 0);
        chk("rst_q_ready", q_ready, 1);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_hit", r_hit, 0);
        chk("rst_r_idx", r_idx, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_map_sel", map_sel, 0);
        chk("post_rst_q_ready", q_ready, 1);

        // Directed vectors.
        foreach (vecs[v]) begin
            set_map(vecs[v].map);
            query(vecs[v].l, vecs[v].r, vecs[v].t, vecs[v].b, 1'b0, -1, -1, hit, idx, lat);
            chk($sformatf("vec%0d_hit", v), hit, vecs[v].hit);
            chk($sformatf("vec%0d_idx", v), idx, vecs[v].idx);
            chk($sformatf("vec%0d_lat", v), lat, vecs[v].lat);
            release_result();
        end

        // new_map twice during a scan: deferred, collapsed, applied once in IDLE.
        set_map(0);
        query(610, 630, 10, 30, 1'b0, 3, 6, hit, idx, lat);
        chk("defer_lat", lat, 12);
        old = int'(map_sel);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_r_valid", r_valid, 1);
            chk("hold_r_hit", r_hit, 0);
            chk("hold_r_idx", r_idx, 0);
            chk("hold_map_sel", map_sel, old);
        end
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        chk("defer_idle_map_old", map_sel, old);
        p = predict();
        @(negedge clk);
        chk("defer_applied", map_sel, p);
        chk("defer_changed", map_sel != 2'(old), 1);
        repeat (3) @(negedge clk);
        chk("defer_collapsed", map_sel, p);

        // Reset mid-scan aborts with no result.
        query(610, 630, 10, 30, 1'b1, -1, -1, hit, idx, lat);
        release_result();
        q_left = 10'd610; q_right = 10'd630; q_top = 9'd10; q_bottom = 9'd30;
        q_valid = 1'b1;
        @(negedge clk);
        q_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #2;
        chk("abort_r_valid", r_valid, 0);
        chk("abort_q_ready", q_ready, 1);
        chk("abort_map_sel", map_sel, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (14) begin
            @(negedge clk);
            chk("abort_no_result", r_valid, 0);
        end

        // Randomized queries, some combined with a map change at the same edge.
        for (int it = 0; it < 40; it++) begin
            wm = ($urandom % 4 == 0);
            if (wm) m = predict();
            else begin
                m = int'($urandom % 4);
                set_map(m);
            end
            if ($urandom % 2 == 1) begin
                j = int'($urandom % N);
                l = int'(tl[m][j]) + int'($urandom_range(0, 20)) - 15;
                t = int'(tt[m][j]) + int'($urandom_range(0, 20)) - 15;
            end else begin
                l = int'($urandom_range(0, 600));
                t = int'($urandom_range(0, 450));
            end
            if (l < 0) l = 0;
            if (l > 600) l = 600;
            if (t < 0) t = 0;
            if (t > 450) t = 450;
            r = l + int'($urandom_range(1, 40));
            b = t + int'($urandom_range(1, 30));
            model(m, l, r, t, b, ehit, eidx, elat);
            query(l, r, t, b, wm, -1, -1, hit, idx, lat);
            chk("rnd_map", map_sel, m);
            chk("rnd_hit", hit, ehit);
            chk("rnd_idx", idx, eidx);
            chk("rnd_lat", lat, elat);
            release_result();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
